// File: rtl/vpu_lane_exec_pkg.sv
// Shared types and sizing for the VPU lane execute stage.
// Holds the opcode and FSM state enums plus small decode helpers.
package vpu_lane_exec_pkg;

   localparam int OPERAND_WIDTH   = 16;
   localparam int VLANE_CNT       = 16;
   localparam int SRAM_R_PORT_CNT = 2;
   localparam int VCNT_W          = 8;
   localparam int VEC_W           = OPERAND_WIDTH * VLANE_CNT;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      MUL  = 3'd2,
      MAX  = 3'd3,
      MIN  = 3'd4,
      RELU = 3'd5
   } VPU_EXEC_OP_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } exec_state_t;

   function automatic logic op_is_legal(input logic [2:0] op);
      return op <= 3'd5;
   endfunction

   // Port 0 carries src A, port 1 carries src B; RELU only reads A.
   function automatic logic [SRAM_R_PORT_CNT-1:0] op_ports(input VPU_EXEC_OP_t op);
      return (op == RELU) ? 2'b01 : 2'b11;
   endfunction

endpackage

// File: rtl/vpu_lane_alu.sv
// One-lane combinational ALU; signed two's complement, results wrap modulo 2^OW.
module vpu_lane_alu
   import vpu_lane_exec_pkg::*;
(
   input  logic [OPERAND_WIDTH-1:0] a_i,
   input  logic [OPERAND_WIDTH-1:0] b_i,
   input  VPU_EXEC_OP_t             op_i,
   output logic [OPERAND_WIDTH-1:0] res_o
);

   logic signed [OPERAND_WIDTH-1:0] a_s;
   logic signed [OPERAND_WIDTH-1:0] b_s;

   assign a_s = a_i;
   assign b_s = b_i;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      res_o = '0;
      case (op_i)
         ADD:     res_o = a_i + b_i;
         SUB:     res_o = a_i - b_i;
         MUL:     res_o = a_i * b_i;
         MAX:     res_o = (a_s > b_s) ? a_i : b_i;
         MIN:     res_o = (a_s < b_s) ? a_i : b_i;
         RELU:    res_o = a_s[OPERAND_WIDTH-1] ? '0 : a_i;
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/vpu_lane_exec.sv
// Execute stage: pops operand vectors, applies an element-wise op across all
// lanes through a two-stage pipeline and pushes results to the dst port.
module vpu_lane_exec
   import vpu_lane_exec_pkg::*;
(
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         start_i,
   input  logic [2:0]                                   opcode_i,
   input  logic [VCNT_W-1:0]                            vec_cnt_i,
   input  logic                                         reset_cmd_i,
   input  logic [SRAM_R_PORT_CNT-1:0][VEC_W-1:0]        rdata_i,
   input  logic [SRAM_R_PORT_CNT-1:0]                   rdempty_i,
   output logic [SRAM_R_PORT_CNT-1:0]                   rden_o,
   output logic                                         wb_data_wren_o,
   output logic [VEC_W-1:0]                             wb_data_o,
   input  logic                                         wb_ready_i,
   output logic                                         busy_o,
   output logic                                         done_o,
   output logic                                         err_o
);

   exec_state_t                 state_q, state_d;
   VPU_EXEC_OP_t                op_q, op_d;
   logic [VCNT_W-1:0]           vec_cnt_q, vec_cnt_d;
   logic [VCNT_W-1:0]           iss_cnt_q, iss_cnt_d;
   logic [VCNT_W-1:0]           wb_cnt_q, wb_cnt_d;
   logic                        s1_valid_q, s1_valid_d;
   logic [VEC_W-1:0]            s1_a_q, s1_a_d;
   logic [VEC_W-1:0]            s1_b_q, s1_b_d;
   logic                        s2_valid_q, s2_valid_d;
   logic [VEC_W-1:0]            s2_data_q, s2_data_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;

   logic [SRAM_R_PORT_CNT-1:0]  needed;
   logic                        adv;
   logic                        issue;
   logic                        accept;
   logic [VEC_W-1:0]            alu_res;

   assign needed = op_ports(op_q);
   assign adv    = !s2_valid_q || wb_ready_i;
   assign accept = s2_valid_q && wb_ready_i;
   assign issue  = (state_q == ST_RUN) && (iss_cnt_q < vec_cnt_q) &&
                   ((needed & rdempty_i) == '0) && adv && !reset_cmd_i;

   for (genvar k = 0; k < VLANE_CNT; k++) begin : g_lane
      vpu_lane_alu u_alu (
         .a_i   (s1_a_q[k*OPERAND_WIDTH +: OPERAND_WIDTH]),
         .b_i   (s1_b_q[k*OPERAND_WIDTH +: OPERAND_WIDTH]),
         .op_i  (op_q),
         .res_o (alu_res[k*OPERAND_WIDTH +: OPERAND_WIDTH])
      );
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      vec_cnt_d  = vec_cnt_q;
      iss_cnt_d  = iss_cnt_q;
      wb_cnt_d   = wb_cnt_q;
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      // A stalled write-back freezes both stages so wb_data_o stays stable.
      if (adv) begin
         s1_valid_d = issue;
         if (issue) begin
            s1_a_d = rdata_i[0];
            s1_b_d = rdata_i[1];
         end
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) s2_data_d = alu_res;
      end
      if (issue)  iss_cnt_d = iss_cnt_q + VCNT_W'(1);
      if (accept) wb_cnt_d  = wb_cnt_q + VCNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (!op_is_legal(opcode_i)) begin
                  err_d = 1'b1;
               end else if (vec_cnt_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = ST_RUN;
                  op_d      = VPU_EXEC_OP_t'(opcode_i);
                  vec_cnt_d = vec_cnt_i;
                  iss_cnt_d = '0;
                  wb_cnt_d  = '0;
               end
            end
         end
         ST_RUN: begin
            if (accept && (wb_cnt_q + VCNT_W'(1) == vec_cnt_q)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Controller flush overrides everything decided above.
      if (reset_cmd_i) begin
         state_d    = ST_IDLE;
         iss_cnt_d  = '0;
         wb_cnt_d   = '0;
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
         done_d     = 1'b0;
         err_d      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         op_q       <= ADD;
         vec_cnt_q  <= '0;
         iss_cnt_q  <= '0;
         wb_cnt_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         vec_cnt_q  <= vec_cnt_d;
         iss_cnt_q  <= iss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign rden_o         = issue ? needed : '0;
   assign wb_data_wren_o = s2_valid_q;
   assign wb_data_o      = s2_data_q;
   assign busy_o         = (state_q != ST_IDLE);
   assign done_o         = done_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_vpu_lane_exec.sv
// Directed self-checking bench for vpu_lane_exec with FWFT operand queue models
// and a write-back monitor recording accepted results and their cycle stamps.
module tb_vpu_lane_exec;
   import vpu_lane_exec_pkg::*;

   localparam int OW = OPERAND_WIDTH;
   localparam int VW = VEC_W;

   logic                                  clk = 1'b0;
   logic                                  rst_n = 1'b0;
   logic                                  start_i = 1'b0;
   logic [2:0]                            opcode_i = 3'd0;
   logic [VCNT_W-1:0]                     vec_cnt_i = '0;
   logic                                  reset_cmd_i = 1'b0;
   logic [SRAM_R_PORT_CNT-1:0][VW-1:0]    rdata_i;
   logic [SRAM_R_PORT_CNT-1:0]            rdempty_i;
   logic [SRAM_R_PORT_CNT-1:0]            rden_o;
   logic                                  wb_data_wren_o;
   logic [VW-1:0]                         wb_data_o;
   logic                                  wb_ready_i = 1'b1;
   logic                                  busy_o, done_o, err_o;

   int checks = 0;
   int errors = 0;

   vpu_lane_exec dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .opcode_i       (opcode_i),
      .vec_cnt_i      (vec_cnt_i),
      .reset_cmd_i    (reset_cmd_i),
      .rdata_i        (rdata_i),
      .rdempty_i      (rdempty_i),
      .rden_o         (rden_o),
      .wb_data_wren_o (wb_data_wren_o),
      .wb_data_o      (wb_data_o),
      .wb_ready_i     (wb_ready_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   // FWFT queue models: head pointer advances on the edge that ends a pop cycle.
   logic [VW-1:0] qmem [SRAM_R_PORT_CNT][64];
   logic [5:0]    rd_ptr [SRAM_R_PORT_CNT] = '{6'd0, 6'd0};
   logic [5:0]    wr_ptr [SRAM_R_PORT_CNT] = '{6'd0, 6'd0};
   int            pop_cnt [SRAM_R_PORT_CNT] = '{0, 0};

   assign rdata_i[0]   = qmem[0][rd_ptr[0]];
   assign rdata_i[1]   = qmem[1][rd_ptr[1]];
   assign rdempty_i[0] = (rd_ptr[0] == wr_ptr[0]);
   assign rdempty_i[1] = (rd_ptr[1] == wr_ptr[1]);

   always @(posedge clk) begin
      for (int p = 0; p < SRAM_R_PORT_CNT; p++) begin
         if (rden_o[p]) begin
            rd_ptr[p]  <= rd_ptr[p] + 6'd1;
            pop_cnt[p] <= pop_cnt[p] + 1;
         end
      end
   end

   logic [VW-1:0] acc_q [$];
   int            acc_cyc [$];
   int            cyc = 0;
   int            done_cnt = 0;
   int            err_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wb_data_wren_o && wb_ready_i) begin
         acc_q.push_back(wb_data_o);
         acc_cyc.push_back(cyc);
      end
      if (done_o) done_cnt++;
      if (err_o)  err_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int p, input logic [VW-1:0] v);
      qmem[p][wr_ptr[p]] = v;
      wr_ptr[p] = wr_ptr[p] + 6'd1;
   endtask

   task automatic flush_queues();
      for (int p = 0; p < SRAM_R_PORT_CNT; p++) wr_ptr[p] = rd_ptr[p];
   endtask

   task automatic start_cmd(input logic [2:0] op, input int cnt);
      drive_cycle();
      start_i   = 1'b1;
      opcode_i  = op;
      vec_cnt_i = VCNT_W'(cnt);
      drive_cycle();
      start_i   = 1'b0;
   endtask

   task automatic wait_acc(input int n, output bit ok);
      int budget = 100;
      while (acc_q.size() < n && budget > 0) begin
         tick();
         budget--;
      end
      ok = (acc_q.size() >= n);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_accept: got %0d accepts, required %0d", acc_q.size(), n);
      end
   endtask

   function automatic logic [VW-1:0] splat(input logic [OW-1:0] v);
      logic [VW-1:0] r;
      for (int k = 0; k < VLANE_CNT; k++) r[k*OW +: OW] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] add_a(input int j);
      logic [VW-1:0] r;
      for (int k = 0; k < VLANE_CNT; k++) r[k*OW +: OW] = OW'(k + 1 + 16 * j);
      return r;
   endfunction

   function automatic logic [VW-1:0] add_exp(input int j);
      logic [VW-1:0] r;
      for (int k = 0; k < VLANE_CNT; k++) r[k*OW +: OW] = OW'(101 + k + 16 * j);
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
      checks++; if (wb_data_wren_o !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b required 0", wb_data_wren_o); end
      checks++; if (rden_o !== 2'b00) begin errors++; $display("FAIL reset_rden: got %b required 00", rden_o); end
      checks++; if (done_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_pulses: done %b err %b required 0 0", done_o, err_o); end
      checks++; if (wb_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", wb_data_o); end
      drive_cycle();
      rst_n = 1'b1;
      repeat (2) drive_cycle();
   endtask

   task automatic test_add();
      int base, p0, p1, c0;
      bit ok;
      flush_queues();
      base = acc_q.size(); p0 = pop_cnt[0]; p1 = pop_cnt[1];
      for (int j = 0; j < 4; j++) begin
         push(0, add_a(j));
         push(1, splat(16'd100));
      end
      start_cmd(3'd0, 4);
      c0 = cyc;
      wait_acc(base + 4, ok);
      if (ok) begin
         for (int j = 0; j < 4; j++) begin
            checks++; if (acc_q[base+j] !== add_exp(j)) begin errors++; $display("FAIL add_vec%0d: got %h required %h", j, acc_q[base+j], add_exp(j)); end
         end
         checks++; if (acc_cyc[base] - c0 !== 2) begin errors++; $display("FAIL add_latency: got %0d required 2", acc_cyc[base] - c0); end
         checks++; if (acc_cyc[base+3] - acc_cyc[base] !== 3) begin errors++; $display("FAIL add_back_to_back: got span %0d required 3", acc_cyc[base+3] - acc_cyc[base]); end
         checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL add_done_early: got %b required 0", done_o); end
         tick();
         checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL add_done: got %b required 1", done_o); end
         tick();
         checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL add_idle: done %b busy %b required 0 0", done_o, busy_o); end
      end
      checks++; if (pop_cnt[0] - p0 !== 4 || pop_cnt[1] - p1 !== 4) begin errors++; $display("FAIL add_pops: got %0d/%0d required 4/4", pop_cnt[0] - p0, pop_cnt[1] - p1); end
      repeat (2) tick();
   endtask

   task automatic test_stall();
      int base, d0, pst;
      logic [VW-1:0] snap;
      bit ok;
      flush_queues();
      base = acc_q.size(); d0 = done_cnt; pst = pop_cnt[0];
      for (int j = 0; j < 4; j++) begin
         push(0, add_a(j));
         push(1, splat(16'd100));
      end
      start_cmd(3'd0, 4);
      wait_acc(base + 1, ok);
      drive_cycle();
      wb_ready_i = 1'b0;
      tick();
      snap = wb_data_o;
      pst = pop_cnt[0];
      checks++; if (snap !== add_exp(1) || wb_data_wren_o !== 1'b1) begin errors++; $display("FAIL stall_head: got %h wren %b required %h 1", snap, wb_data_wren_o, add_exp(1)); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (wb_data_o !== snap) begin errors++; $display("FAIL stall_stable%0d: got %h required %h", i, wb_data_o, snap); end
      end
      checks++; if (pop_cnt[0] !== pst) begin errors++; $display("FAIL stall_pops: got %0d required %0d", pop_cnt[0], pst); end
      drive_cycle();
      wb_ready_i = 1'b1;
      wait_acc(base + 4, ok);
      repeat (4) tick();
      checks++; if (acc_q.size() - base !== 4) begin errors++; $display("FAIL stall_accepts: got %0d required 4", acc_q.size() - base); end
      if (acc_q.size() - base >= 4) begin
         checks++; if (acc_q[base+3] !== add_exp(3)) begin errors++; $display("FAIL stall_last: got %h required %h", acc_q[base+3], add_exp(3)); end
      end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stall_done: got %0d pulses required 1", done_cnt - d0); end
   endtask

   task automatic run_one(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [VW-1:0] exp, input string name);
      int base;
      bit ok;
      flush_queues();
      base = acc_q.size();
      push(0, a);
      push(1, b);
      start_cmd(op, 1);
      wait_acc(base + 1, ok);
      if (ok) begin
         checks++; if (acc_q[base] !== exp) begin errors++; $display("FAIL %s: got %h required %h", name, acc_q[base], exp); end
      end
      repeat (2) tick();
   endtask

   task automatic test_alu_ops();
      logic [VW-1:0] ma, mb, me;
      for (int k = 0; k < VLANE_CNT; k++) begin
         ma[k*OW +: OW] = (k % 2 == 0) ? 16'h0100 : 16'h0003;
         mb[k*OW +: OW] = (k % 2 == 0) ? 16'h0100 : 16'hFFFE;
         me[k*OW +: OW] = (k % 2 == 0) ? 16'h0000 : 16'hFFFA;
      end
      run_one(3'd3, splat(16'hFFFB), splat(16'h0003), splat(16'h0003), "max");
      run_one(3'd4, splat(16'hFFFB), splat(16'h0003), splat(16'hFFFB), "min");
      run_one(3'd1, splat(16'hFFFB), splat(16'h0003), splat(16'hFFF8), "sub");
      run_one(3'd2, ma, mb, me, "mul_wrap");
      run_one(3'd0, splat(16'h7FFF), splat(16'h0001), splat(16'h8000), "add_wrap");
   endtask

   task automatic test_relu();
      logic [VW-1:0] v0, v1, e0, e1;
      int base, p0, p1;
      bit ok;
      flush_queues();
      base = acc_q.size(); p0 = pop_cnt[0]; p1 = pop_cnt[1];
      for (int k = 0; k < VLANE_CNT; k++) begin
         v0[k*OW +: OW] = (k % 2 == 1) ? OW'(-(k * 7)) : OW'(k * 7);
         e0[k*OW +: OW] = (k % 2 == 1) ? 16'h0000 : OW'(k * 7);
         v1[k*OW +: OW] = (k % 2 == 1) ? 16'h7FFF : 16'h8000;
         e1[k*OW +: OW] = (k % 2 == 1) ? 16'h7FFF : 16'h0000;
      end
      push(0, v0);
      push(0, v1);
      start_cmd(3'd5, 2);
      wait_acc(base + 2, ok);
      if (ok) begin
         checks++; if (acc_q[base] !== e0) begin errors++; $display("FAIL relu_vec0: got %h required %h", acc_q[base], e0); end
         checks++; if (acc_q[base+1] !== e1) begin errors++; $display("FAIL relu_vec1: got %h required %h", acc_q[base+1], e1); end
      end
      checks++; if (pop_cnt[0] - p0 !== 2 || pop_cnt[1] - p1 !== 0) begin errors++; $display("FAIL relu_pops: got %0d/%0d required 2/0", pop_cnt[0] - p0, pop_cnt[1] - p1); end
      repeat (2) tick();
   endtask

   task automatic test_reset_cmd();
      int base, d0;
      bit ok;
      flush_queues();
      base = acc_q.size();
      for (int j = 0; j < 8; j++) begin
         push(0, add_a(j));
         push(1, splat(16'd100));
      end
      start_cmd(3'd0, 8);
      wait_acc(base + 2, ok);
      drive_cycle();
      reset_cmd_i = 1'b1;
      d0 = done_cnt;
      drive_cycle();
      reset_cmd_i = 1'b0;
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b required 0", busy_o); end
      checks++; if (wb_data_wren_o !== 1'b0 || rden_o !== 2'b00) begin errors++; $display("FAIL flush_strobes: wren %b rden %b required 0 00", wb_data_wren_o, rden_o); end
      repeat (3) tick();
      checks++; if (done_cnt !== d0) begin errors++; $display("FAIL flush_no_done: got %0d pulses required 0", done_cnt - d0); end
      flush_queues();
      base = acc_q.size();
      d0 = done_cnt;
      for (int j = 0; j < 2; j++) begin
         push(0, add_a(j + 4));
         push(1, splat(16'd100));
      end
      start_cmd(3'd0, 2);
      wait_acc(base + 2, ok);
      repeat (3) tick();
      if (ok) begin
         checks++; if (acc_q[base] !== add_exp(4) || acc_q[base+1] !== add_exp(5)) begin errors++; $display("FAIL flush_rerun: got %h %h required %h %h", acc_q[base], acc_q[base+1], add_exp(4), add_exp(5)); end
      end
      checks++; if (acc_q.size() - base !== 2 || done_cnt - d0 !== 1) begin errors++; $display("FAIL flush_rerun_count: accepts %0d done %0d required 2 1", acc_q.size() - base, done_cnt - d0); end
   endtask

   task automatic test_err_and_zero();
      int p0, p1;
      flush_queues();
      push(0, splat(16'd1));
      push(1, splat(16'd2));
      p0 = pop_cnt[0]; p1 = pop_cnt[1];
      for (int op = 6; op < 8; op++) begin
         start_cmd(3'(op), 3);
         tick();
         checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL err_op%0d: err %b busy %b required 1 0", op, err_o, busy_o); end
         tick();
         checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_pulse_op%0d: got %b required 0", op, err_o); end
      end
      start_cmd(3'd0, 0);
      tick();
      checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL zero_done: done %b busy %b required 1 0", done_o, busy_o); end
      tick();
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_pulse: got %b required 0", done_o); end
      checks++; if (pop_cnt[0] !== p0 || pop_cnt[1] !== p1) begin errors++; $display("FAIL err_zero_pops: got %0d/%0d extra pops required 0/0", pop_cnt[0] - p0, pop_cnt[1] - p1); end
   endtask

   task automatic test_busy_start();
      int base, d0, e0, p0;
      bit ok;
      flush_queues();
      base = acc_q.size(); d0 = done_cnt; e0 = err_cnt; p0 = pop_cnt[0];
      for (int j = 0; j < 2; j++) begin
         push(0, add_a(j));
         push(1, splat(16'd100));
      end
      wb_ready_i = 1'b0;
      start_cmd(3'd0, 2);
      start_cmd(3'd7, 5);
      tick();
      checks++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL busy_start: err %b busy %b required 0 1", err_o, busy_o); end
      drive_cycle();
      wb_ready_i = 1'b1;
      wait_acc(base + 2, ok);
      repeat (4) tick();
      checks++; if (acc_q.size() - base !== 2 || done_cnt - d0 !== 1 || err_cnt !== e0) begin errors++; $display("FAIL busy_result: accepts %0d done %0d err %0d required 2 1 0", acc_q.size() - base, done_cnt - d0, err_cnt - e0); end
      checks++; if (pop_cnt[0] - p0 !== 2) begin errors++; $display("FAIL busy_pops: got %0d required 2", pop_cnt[0] - p0); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_stall();
      test_alu_ops();
      test_relu();
      test_reset_cmd();
      test_err_and_zero();
      test_busy_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
